fwd_hazard_ctrl: RTL
====================

// Module: fwd_hazard_ctrl
//
// PURPOSE
// - Drives the rs1mux/rs2mux forwarding selects and the load-use stall for the 5-stage RV32I pipeline.
// - Sits beside the ID stage and keeps a shadow of destination info for the instructions in EX and MEM.
// - On each ID->EX advance it registers select codes that the EX-stage operand muxes use the next cycle.
// - Select encodings follow rs1mux/rs2mux: rs1_out/rs2_out=2'b00, alu_out=2'b01, wb_out=2'b10.
//
// PARAMETERS
// - REG_AW  5   register-index width
// - CNT_W   32  width of the performance counters (used only with HAZ_PERF_CNT_EN)
//
// PORTS
// - clk             in   1       clock; all state updates on posedge
// - rst             in   1       synchronous, active-high reset
// - id_valid        in   1       ID holds a real instruction
// - id_rs1          in   REG_AW  ID source register 1
// - id_rs2          in   REG_AW  ID source register 2
// - id_use_rs1      in   1       ID instruction reads rs1
// - id_use_rs2      in   1       ID instruction reads rs2
// - id_rd           in   REG_AW  ID destination register
// - id_wr_rd        in   1       ID instruction writes rd
// - id_is_load      in   1       ID instruction is a load: lb/lbu/lh/lhu/lw
// - mem_stall       in   1       global freeze from I/D cache miss
// - flush           in   1       branch/jump redirect resolved in EX; kills IF/ID
// - rs1mux_sel      out  2       registered EX-stage rs1 operand select
// - rs2mux_sel      out  2       registered EX-stage rs2 operand select
// - load_use_stall  out  1       combinational: hold PC and IF/ID, insert bubble into ID/EX
// - stall_cnt       out  CNT_W   count of cycles with load_use_stall asserted
// - fwd_cnt         out  CNT_W   count of ID->EX issues with a non-zero select
//
// BEHAVIOUR
// - State: ex_{v,rd,wr,ld} for the instruction in EX, and mem_{v,rd,wr} for the instruction in MEM.
// - Reset (rst=1 at posedge): all *_v=0, rs1mux_sel=rs2mux_sel=2'b00, counters=0.
// - Reset wins over mem_stall and flush. rst mid-stall leaves no stale hazard.
// - match_ex(r) = ex_v & ex_wr & (ex_rd==r) & (r!=0).
// - match_mem(r) = mem_v & mem_wr & (mem_rd==r) & (r!=0). Register x0 is never forwarded or stalled on.
// - hazard = id_valid & ex_ld & ((id_use_rs1 & match_ex(id_rs1)) | (id_use_rs2 & match_ex(id_rs2))).
// - load_use_stall = hazard & ~mem_stall & ~flush. It is the only combinational output.
// - Priority per posedge: rst > mem_stall > flush > load_use_stall > normal advance.
// - mem_stall=1: all state and selects hold their values. flush is ignored; the branch unit holds flush until mem_stall=0.
// - Normal advance updates the shadow:
//   - mem_* <= ex_*.
//   - ex_* <= {id_valid, id_rd, id_wr_rd, id_is_load}.
//   - sel(r) <= match_ex(r) ? 2'b01 : match_mem(r) ? 2'b10 : 2'b00, evaluated separately for rs1 and rs2.
//   - EX match has priority over MEM match, so the youngest producer wins.
//   - A source not used (id_use_rsN=0) gives sel 2'b00.
// - load_use_stall: mem_* <= ex_*; ex_v <= 0; both selects <= 2'b00.
//   - Next cycle the load is in MEM, so the retried instruction receives 2'b10 (wb_out). The stall lasts exactly 1 cycle.
// - flush: mem_* <= ex_*, so the branch in EX proceeds; ex_v <= 0; selects <= 2'b00.
// - Latency: a select is registered on the ID->EX edge and is valid for the whole EX cycle.
// - Forwarding from a producer in WB into a consumer in ID is not handled here. The regfile must be write-before-read.
//
// CONFIGURATION
// - HAZ_PERF_CNT_EN defined:
//   - stall_cnt increments on each posedge with load_use_stall=1.
//   - fwd_cnt increments on each normal advance where rs1 sel!=0 or rs2 sel!=0 (+1 per instruction, not per operand).
//   - Both counters wrap modulo 2^CNT_W and hold during mem_stall.
// - HAZ_PERF_CNT_EN undefined: stall_cnt and fwd_cnt are tied to 0 and no counter flops are built.
//
// TESTING
// - Back-to-back ALU: add x5 in EX, then ID add x6,x5,x5 -> next cycle rs1mux_sel=rs2mux_sel=2'b01, load_use_stall=0.
// - Distance 2: x5 producer in MEM, ID reads rs2=x5 -> rs2mux_sel=2'b10, rs1mux_sel=2'b00.
// - Load-use: lw x7 in EX, ID reads rs1=x7 -> load_use_stall=1 for exactly 1 cycle, then rs1mux_sel=2'b10.
//   - With HAZ_PERF_CNT_EN, stall_cnt goes 0->1.
// - Distance-1 and distance-2 writers of x5, both valid, ID reads x5 -> sel=2'b01 (youngest wins).
// - x0 and unused sources: EX writes x0, ID reads x0 -> sel=2'b00.
//   - id_use_rs2=0 with an rs2 match -> rs2mux_sel=2'b00.
// - Freeze/flush: load-use with mem_stall=1 for 3 cycles -> load_use_stall=0 and state held.
//   - After release the stall fires once.
//   - flush=1 with a load-use hazard present -> no stall, ex_v=0, selects 2'b00.
//   - rst mid-sequence -> all outputs return to 0 next cycle.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - EX/MEM forwarding selects and load-use stall for the 5-stage RV32I pipeline
// Optional performance counters are built only when HAZ_PERF_CNT_EN is defined.
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr_rd,
  input  logic              id_is_load,
  input  logic              mem_stall,
  input  logic              flush,
  output logic [1:0]        rs1mux_sel,
  output logic [1:0]        rs2mux_sel,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  fwd_cnt
);

  localparam logic [1:0] SEL_RS  = 2'b00;
  localparam logic [1:0] SEL_ALU = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  logic              r_ex_v, r_ex_wr, r_ex_ld;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_mem_v, r_mem_wr;
  logic [REG_AW-1:0] r_mem_rd;
  logic [1:0]        r_rs1_sel, r_rs2_sel;

  logic       w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2;
  logic       w_hazard;
  logic [1:0] w_rs1_nxt, w_rs2_nxt;

  // x0 is hard-wired zero, so it never produces a forwarding or stall match
  assign w_ex_m1  = r_ex_v  & r_ex_wr  & (r_ex_rd  == id_rs1) & (id_rs1 != '0);
  assign w_ex_m2  = r_ex_v  & r_ex_wr  & (r_ex_rd  == id_rs2) & (id_rs2 != '0);
  assign w_mem_m1 = r_mem_v & r_mem_wr & (r_mem_rd == id_rs1) & (id_rs1 != '0);
  assign w_mem_m2 = r_mem_v & r_mem_wr & (r_mem_rd == id_rs2) & (id_rs2 != '0);

  assign w_hazard = id_valid & r_ex_ld &
                    ((id_use_rs1 & w_ex_m1) | (id_use_rs2 & w_ex_m2));
  assign load_use_stall = w_hazard & ~mem_stall & ~flush;

  always_comb begin
    w_rs1_nxt = SEL_RS;
    w_rs2_nxt = SEL_RS;
    if (id_use_rs1) begin
      if (w_ex_m1)       w_rs1_nxt = SEL_ALU;
      else if (w_mem_m1) w_rs1_nxt = SEL_WB;
    end
    if (id_use_rs2) begin
      if (w_ex_m2)       w_rs2_nxt = SEL_ALU;
      else if (w_mem_m2) w_rs2_nxt = SEL_WB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_v    <= 1'b0;
      r_ex_wr   <= 1'b0;
      r_ex_ld   <= 1'b0;
      r_ex_rd   <= '0;
      r_mem_v   <= 1'b0;
      r_mem_wr  <= 1'b0;
      r_mem_rd  <= '0;
      r_rs1_sel <= SEL_RS;
      r_rs2_sel <= SEL_RS;
    end else if (!mem_stall) begin
      // The instruction in EX always moves on; only what enters EX depends on flush/stall
      r_mem_v  <= r_ex_v;
      r_mem_wr <= r_ex_wr;
      r_mem_rd <= r_ex_rd;
      if (flush || w_hazard) begin
        r_ex_v    <= 1'b0;
        r_rs1_sel <= SEL_RS;
        r_rs2_sel <= SEL_RS;
      end else begin
        r_ex_v    <= id_valid;
        r_ex_rd   <= id_rd;
        r_ex_wr   <= id_wr_rd;
        r_ex_ld   <= id_is_load;
        r_rs1_sel <= w_rs1_nxt;
        r_rs2_sel <= w_rs2_nxt;
      end
    end
  end

  assign rs1mux_sel = r_rs1_sel;
  assign rs2mux_sel = r_rs2_sel;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_fwd_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else if (!mem_stall) begin
      if (load_use_stall)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      else if (!flush && ((w_rs1_nxt != SEL_RS) || (w_rs2_nxt != SEL_RS)))
        r_fwd_cnt <= r_fwd_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign fwd_cnt   = r_fwd_cnt;
`else
  assign stall_cnt = '0;
  assign fwd_cnt   = '0;
`endif

endmodule
